// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor: registered voter and replica health monitor for the
// triplicated c17 cone outputs (N22/N23 per replica).
// Optional build macro TMR_ERR_COUNT_EN adds per-replica saturating
// mismatch counters on err_cnt (replica i in slice i).
//
// Replica FSM states:
//   state      | meaning
//   ST_OK      | replica agrees with the vote
//   ST_SUSPECT | replica disagreed on the last cnt consecutive valid samples
//   ST_FAILED  | replica retired; sticky until fault_clr or reset
module tmr_vote_monitor #(
   parameter int WIDTH       = 2,
   parameter int FAIL_THRESH = 3
`ifdef TMR_ERR_COUNT_EN
   ,
   parameter int CNT_W       = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] rep_a,
   input  logic [WIDTH-1:0] rep_b,
   input  logic [WIDTH-1:0] rep_c,
   input  logic             fault_clr,
`ifdef TMR_ERR_COUNT_EN
   output logic [3*CNT_W-1:0] err_cnt,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             mis_any,
   output logic [2:0]       rep_failed
);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAILED  = 2'd2
   } rep_state_t;

   localparam logic [3:0] THRESH = 4'(FAIL_THRESH);

   rep_state_t       state [3];
   logic [3:0]       cnt   [3];
   logic [WIDTH-1:0] rep   [3];
   logic [WIDTH-1:0] maj;
   logic [WIDTH-1:0] vote_data;
   logic             vote_err;
   logic [2:0]       mis;
   logic             advance;

   assign rep[0] = rep_a;
   assign rep[1] = rep_b;
   assign rep[2] = rep_c;

   assign maj = (rep_a & rep_b) | (rep_a & rep_c) | (rep_b & rep_c);

   // Mismatch is only meaningful in full TMR mode; degraded modes freeze the FSMs.
   assign mis[0]  = (rep_failed == 3'b000) && (rep_a != maj);
   assign mis[1]  = (rep_failed == 3'b000) && (rep_b != maj);
   assign mis[2]  = (rep_failed == 3'b000) && (rep_c != maj);
   assign advance = in_valid && (rep_failed == 3'b000);

   // Select the voted word from the survivors named by the registered mask.
   always_comb begin
      vote_data = '0;
      vote_err  = 1'b0;
      case (rep_failed)
         3'b000: vote_data = maj;
         3'b001: begin vote_data = rep_b; vote_err = (rep_b != rep_c); end
         3'b010: begin vote_data = rep_a; vote_err = (rep_a != rep_c); end
         3'b100: begin vote_data = rep_a; vote_err = (rep_a != rep_b); end
         3'b011: begin vote_data = rep_c; vote_err = 1'b1; end
         3'b101: begin vote_data = rep_b; vote_err = 1'b1; end
         3'b110: begin vote_data = rep_a; vote_err = 1'b1; end
         default: begin vote_data = '0; vote_err = 1'b1; end
      endcase
   end

   // Per-replica health FSMs with consecutive-mismatch counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            state[i] <= ST_OK;
            cnt[i]   <= '0;
         end
         rep_failed <= 3'b000;
      end else if (fault_clr) begin
         for (int i = 0; i < 3; i++) begin
            state[i] <= ST_OK;
            cnt[i]   <= '0;
         end
         rep_failed <= 3'b000;
      end else if (advance) begin
         for (int i = 0; i < 3; i++) begin
            case (state[i])
               ST_OK: begin
                  if (mis[i]) begin
                     cnt[i] <= 4'd1;
                     if (THRESH == 4'd1) begin
                        state[i]      <= ST_FAILED;
                        rep_failed[i] <= 1'b1;
                     end else begin
                        state[i] <= ST_SUSPECT;
                     end
                  end
               end
               ST_SUSPECT: begin
                  if (mis[i]) begin
                     cnt[i] <= cnt[i] + 4'd1;
                     if (cnt[i] + 4'd1 == THRESH) begin
                        state[i]      <= ST_FAILED;
                        rep_failed[i] <= 1'b1;
                     end
                  end else begin
                     state[i] <= ST_OK;
                     cnt[i]   <= '0;
                  end
               end
               ST_FAILED: state[i] <= ST_FAILED;
               default:   state[i] <= ST_OK;
            endcase
         end
      end
   end

   // Output register; data/err/mis_any hold across idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
         mis_any   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= vote_data;
            out_err  <= vote_err;
            mis_any  <= |mis;
         end
      end
   end

`ifdef TMR_ERR_COUNT_EN
   // Saturating per-replica mismatch counters; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (in_valid) begin
         for (int i = 0; i < 3; i++) begin
            if (mis[i] && (err_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
               err_cnt[i*CNT_W +: CNT_W] <= err_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor with a behavioural reference model
// (survivor lists and consecutive-mismatch counts) compared every cycle.
module tb_tmr_vote_monitor;

   localparam int WIDTH       = 2;
   localparam int FAIL_THRESH = 3;
   localparam int CNT_W       = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] rep_a = '0, rep_b = '0, rep_c = '0;
   logic             fault_clr = 1'b0;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_err;
   logic             mis_any;
   logic [2:0]       rep_failed;
`ifdef TMR_ERR_COUNT_EN
   logic [3*CNT_W-1:0] err_cnt;
`endif

   tmr_vote_monitor #(.WIDTH(WIDTH), .FAIL_THRESH(FAIL_THRESH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .rep_a(rep_a), .rep_b(rep_b), .rep_c(rep_c), .fault_clr(fault_clr),
`ifdef TMR_ERR_COUNT_EN
      .err_cnt(err_cnt),
`endif
      .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
      .mis_any(mis_any), .rep_failed(rep_failed)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int         consec   [3];
   bit         m_failed [3];
   int         m_errcnt [3];
   logic       exp_valid = 1'b0;
   logic [1:0] exp_data = '0;
   logic       exp_err = 1'b0;
   logic       exp_mis = 1'b0;
   logic [2:0] exp_failed = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         consec[i] = 0; m_failed[i] = 0; m_errcnt[i] = 0;
      end
      exp_valid = 0; exp_data = '0; exp_err = 0; exp_mis = 0; exp_failed = '0;
   endtask

   // Apply one clock edge's worth of behaviour to the model.
   task automatic model_edge(input bit v, input logic [1:0] a, b, c, input bit clr);
      logic [1:0] r [3];
      logic [1:0] maj;
      int         surv [$];
      bit         mis [3];
      r[0] = a; r[1] = b; r[2] = c;
      for (int i = 0; i < 3; i++) begin
         mis[i] = 0;
         if (!m_failed[i]) surv.push_back(i);
      end
      exp_valid = v;
      if (v) begin
         for (int k = 0; k < 2; k++)
            maj[k] = (int'(r[0][k]) + int'(r[1][k]) + int'(r[2][k])) >= 2;
         if (surv.size() == 3) begin
            exp_data = maj; exp_err = 0;
            for (int i = 0; i < 3; i++) mis[i] = (r[i] != maj);
         end else if (surv.size() == 2) begin
            exp_data = r[surv[0]]; exp_err = (r[surv[0]] != r[surv[1]]);
         end else if (surv.size() == 1) begin
            exp_data = r[surv[0]]; exp_err = 1;
         end else begin
            exp_data = '0; exp_err = 1;
         end
         exp_mis = mis[0] | mis[1] | mis[2];
         if (surv.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
               if (mis[i]) begin
                  consec[i]++;
                  if (consec[i] >= FAIL_THRESH) m_failed[i] = 1;
                  if (m_errcnt[i] < (1 << CNT_W) - 1) m_errcnt[i]++;
               end else begin
                  consec[i] = 0;
               end
            end
         end
      end
      if (clr) begin
         for (int i = 0; i < 3; i++) begin consec[i] = 0; m_failed[i] = 0; end
      end
      exp_failed = {m_failed[2], m_failed[1], m_failed[0]};
   endtask

   bit checking = 1'b1;

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         check("out_valid", 32'(out_valid), 32'(exp_valid));
         check("out_data", 32'(out_data), 32'(exp_data));
         check("out_err", 32'(out_err), 32'(exp_err));
         check("mis_any", 32'(mis_any), 32'(exp_mis));
         check("rep_failed", 32'(rep_failed), 32'(exp_failed));
`ifdef TMR_ERR_COUNT_EN
         check("err_cnt", 32'(err_cnt),
               32'({m_errcnt[2][CNT_W-1:0], m_errcnt[1][CNT_W-1:0], m_errcnt[0][CNT_W-1:0]}));
`endif
      end
   end

   task automatic step(input bit v, input logic [1:0] a, b, c, input bit clr = 1'b0);
      in_valid = v; rep_a = a; rep_b = b; rep_c = c; fault_clr = clr;
      @(posedge clk);
      model_edge(v, a, b, c, clr);
      @(negedge clk);
   endtask

   task automatic release_reset();
      #2;
      in_valid = 0; fault_clr = 0; rst_n = 1'b1;
      @(posedge clk);
      model_edge(0, 2'b00, 2'b00, 2'b00, 0);
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_failed", 32'(rep_failed), 32'd0);
      release_reset();

      // all agree
      repeat (5) step(1, 2'b10, 2'b10, 2'b10);
      check("agree_data", 32'(out_data), 32'h2);
      check("agree_err", 32'(out_err), 32'd0);
      check("agree_mis", 32'(mis_any), 32'd0);

      // transient fault on b
      repeat (2) begin
         step(1, 2'b11, 2'b01, 2'b11);
         check("transient_data", 32'(out_data), 32'h3);
         check("transient_mis", 32'(mis_any), 32'd1);
      end
      step(1, 2'b11, 2'b11, 2'b11);
      check("transient_end_mis", 32'(mis_any), 32'd0);
      check("transient_failed", 32'(rep_failed), 32'd0);

      // idle cycle holds data
      step(0, 2'b00, 2'b00, 2'b00);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_hold", 32'(out_data), 32'h3);

      // retirement of b
      step(1, 2'b11, 2'b00, 2'b11);
      step(1, 2'b11, 2'b00, 2'b11);
      check("retire_pre", 32'(rep_failed), 32'd0);
      step(1, 2'b11, 2'b00, 2'b11);
      check("retire_mask", 32'(rep_failed), 32'h2);
      check("retire_data", 32'(out_data), 32'h3);
      step(1, 2'b11, 2'b00, 2'b11);
      check("duplex_agree_data", 32'(out_data), 32'h3);
      check("duplex_agree_err", 32'(out_err), 32'd0);
      check("duplex_agree_mis", 32'(mis_any), 32'd0);

      // duplex disagreement
      step(1, 2'b10, 2'b11, 2'b01);
      check("duplex_dis_data", 32'(out_data), 32'h2);
      check("duplex_dis_err", 32'(out_err), 32'd1);
      check("duplex_dis_mis", 32'(mis_any), 32'd0);

      // clear colliding with a sample
      step(1, 2'b11, 2'b00, 2'b10, 1);
      check("collide_data", 32'(out_data), 32'h3);
      check("collide_err", 32'(out_err), 32'd1);
      check("collide_mask", 32'(rep_failed), 32'd0);
      step(1, 2'b11, 2'b11, 2'b11);
      check("post_clear_err", 32'(out_err), 32'd0);

      // two replicas retire on the same edge (different bits)
      repeat (3) step(1, 2'b01, 2'b10, 2'b00);
      check("dual_retire_mask", 32'(rep_failed), 32'h3);
      check("dual_retire_data", 32'(out_data), 32'h0);
      step(1, 2'b01, 2'b10, 2'b10);
      check("simplex_data", 32'(out_data), 32'h2);
      check("simplex_err", 32'(out_err), 32'd1);
`ifdef TMR_ERR_COUNT_EN
      check("err_cnt_literal", 32'(err_cnt), 32'h00_08_03);
`endif
      step(0, 2'b00, 2'b00, 2'b00, 1);
      check("clear_only_mask", 32'(rep_failed), 32'd0);

      // mixed stimulus
      for (int n = 0; n < 60; n++)
         step(bit'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              bit'($urandom_range(0, 11) == 0));

      // async reset while streaming with a replica retired
      step(0, 2'b00, 2'b00, 2'b00, 1);
      repeat (3) step(1, 2'b00, 2'b11, 2'b11);
      check("pre_reset_mask", 32'(rep_failed), 32'h1);
      in_valid = 1; rep_a = 2'b01; rep_b = 2'b10; rep_c = 2'b10;
      #2 rst_n = 1'b0;
      #1;
      check("areset_valid", 32'(out_valid), 32'd0);
      check("areset_data", 32'(out_data), 32'd0);
      check("areset_err", 32'(out_err), 32'd0);
      check("areset_mis", 32'(mis_any), 32'd0);
      check("areset_mask", 32'(rep_failed), 32'd0);
`ifdef TMR_ERR_COUNT_EN
      check("areset_err_cnt", 32'(err_cnt), 32'd0);
`endif
      model_reset();
      @(negedge clk);
      release_reset();
      step(1, 2'b10, 2'b10, 2'b10);
      check("post_reset_data", 32'(out_data), 32'h2);

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Registered voting and fault-monitor stage directly downstream of the triplicated c17 logic cone.
- Consumes the three replica copies of the primary outputs (N22/N23 per replica) and produces one voted, registered output word.
- Tracks per-replica disagreement. A replica that persistently disagrees is retired, and voting degrades to duplex/simplex with an uncorrectable-error flag.
- Replaces the combinational and/or voters at the output boundary with a clocked, observable stage.

Parameters:
- WIDTH, 2, bits per replica word (N22, N23).
- FAIL_THRESH, 3, consecutive mismatching valid samples that retire a replica (legal range 1..15).
- CNT_W, 8, width of the per-replica saturating error counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  replica words valid this cycle
- rep_a  input  WIDTH  replica 1 outputs
- rep_b  input  WIDTH  replica 2 outputs
- rep_c  input  WIDTH  replica 3 outputs
- fault_clr  input  1  single-cycle pulse; restores all replicas to OK
- out_valid  output  1  voted word valid
- out_data  output  WIDTH  voted word
- out_err  output  1  voted word not guaranteed correct
- mis_any  output  1  at least one replica mismatched on the last valid sample
- rep_failed  output  3  retired-replica mask, bit0 = rep_a

Behaviour:
- Interface: one clock domain (clk); reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_err=0, mis_any=0, rep_failed=000. All replica FSMs are OK and all consecutive counters are 0.
- Latency:
  - Exactly 1 cycle. A sample with in_valid=1 at edge k appears with out_valid=1 after edge k.
  - out_valid=0 the cycle after in_valid=0; out_data/out_err/mis_any hold their last values.
  - No backpressure; one sample per cycle is accepted.
- Voting is bitwise and uses rep_failed as registered at the sampling edge:
  - 0 failed: out_data = majority(a,b,c); out_err=0.
  - 1 failed, survivors agree: out_data = survivor value; out_err=0.
  - 1 failed, survivors differ: out_data = lower-index survivor; out_err=1.
  - 2 failed: out_data = the survivor; out_err=1.
  - 3 failed: out_data=0; out_err=1.
- Mismatch definition:
  - Computed only in 0-failed mode: mis_i = (rep_i != majority) on any bit.
  - mis_any = OR of mis_i; mis_any is 0 in degraded modes.
- Per-replica FSM, advanced only when in_valid=1:
  - OK: mis_i -> SUSPECT with cnt=1. If FAIL_THRESH=1, mis_i goes directly to FAILED.
  - SUSPECT: mis_i -> cnt+1; when cnt reaches FAIL_THRESH -> FAILED. !mis_i -> OK with cnt=0.
  - FAILED: sticky; rep_failed[i]=1 from the cycle after the transition edge.
  - In degraded modes the FSMs of surviving replicas hold state.
- Simultaneous retirement: at most one replica can be the minority of a 3-way vote per bit. If different bits implicate different replicas, each FSM advances independently, so several replicas may retire on the same edge.
- fault_clr:
  - Synchronous; takes priority over FSM advance on the same edge.
  - All FSMs go to OK, counters go to 0, rep_failed=000.
  - The sample voted on that edge still uses the pre-clear mask.
- Reset mid-stream: all state is cleared immediately and asynchronously. No output from the in-flight sample is produced.

Optional Feature:
- Macro: TMR_ERR_COUNT_EN.
- Defined:
  - Adds output err_cnt (3*CNT_W, replica i in slice i).
  - Each slice counts the valid samples where mis_i=1 and saturates at all-ones.
  - The counters are cleared by rst_n only, not by fault_clr.
- Undefined: no err_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- All-agree: in_valid=1 with a=b=c=2'b10 for 5 cycles -> out_data=10 one cycle later, out_err=0, mis_any=0, rep_failed=000.
- Transient fault: a=b=c=11 except b=01 for 2 cycles, then correct -> out_data=11 throughout, mis_any=1 for 2 outputs, rep_failed stays 000, b FSM returns to OK.
- Retirement: b=00 against a=c=11 for 3 valid cycles (FAIL_THRESH=3) -> rep_failed=010 after the third edge; subsequent a=c=11 gives out_data=11, out_err=0.
- Duplex disagreement: after b is retired, a=10, c=01 -> out_data=10, out_err=1, mis_any=0.
- Clear vs. sample collision: rep_failed=010 with fault_clr=1 and in_valid=1 (a=11, b=00, c=10) on the same edge -> that output uses duplex (out_data=11, out_err=1); rep_failed=000 on the next cycle.
- Async reset during streaming: assert rst_n=0 between edges -> all outputs go to 0 immediately; with TMR_ERR_COUNT_EN defined, err_cnt=0.
